reset_sequencer: RTL

- Consumer end of the testbench/board reset source.
- Takes the global power-on reset (rst_100) plus runtime reset requests (push-button, software, watchdog).
- Releases staged, glitch-free resets in a fixed order: memory controller, then peripherals, then the J68 CPU core.
- Latches the cause of the last reset for firmware. Sits at the top level between the clock/reset generator and all clk_100 logic.

---
 rtl/reset_pkg.sv | 17 +
 rtl/reset_sequencer_if.sv | 35 +++
 rtl/reset_debounce.sv | 51 +++++
 rtl/reset_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer slice.
//   state_t     : sequencer FSM states, in release order
//   CAUSE_*     : bit positions inside the one-hot rst_cause vector
package reset_pkg;

    typedef enum logic [1:0] {
        ASSERT   = 2'd0,
        MEM_WAIT = 2'd1,
        PER_REL  = 2'd2,
        RUN      = 2'd3
    } state_t;

    localparam int CAUSE_BTN  = 0;
    localparam int CAUSE_SW   = 1;
    localparam int CAUSE_WDOG = 2;

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of reset request inputs and staged reset outputs around the
// reset sequencer.
//   btn_rst_n     : asynchronous active-low push-button
//   sw_rst_req    : one-cycle software reset pulse
//   wdog_exp      : one-cycle watchdog expiry pulse
//   mem_init_done : memory controller finished calibration/clear
//   rst_mem/per/cpu : staged active-high resets
//   rst_cause     : one-hot cause of last reset (000 = power-on)
//   mem_timeout   : last sequence gave up waiting for memory
//   seq_busy      : any reset output still asserted
// slave is the sequencer side, master is the board/bench side.
interface reset_sequencer_if;

    logic       btn_rst_n;
    logic       sw_rst_req;
    logic       wdog_exp;
    logic       mem_init_done;
    logic       rst_mem;
    logic       rst_per;
    logic       rst_cpu;
    logic [2:0] rst_cause;
    logic       mem_timeout;
    logic       seq_busy;

    modport slave (
        input  btn_rst_n, sw_rst_req, wdog_exp, mem_init_done,
        output rst_mem, rst_per, rst_cpu, rst_cause, mem_timeout, seq_busy
    );

    modport master (
        output btn_rst_n, sw_rst_req, wdog_exp, mem_init_done,
        input  rst_mem, rst_per, rst_cpu, rst_cause, mem_timeout, seq_busy
    );

endinterface

// File: rtl/reset_debounce.sv
// Push-button conditioner: synchronizes the asynchronous active-low button
// into clk_100 and produces a single-cycle fire pulse once it has been held
// low for DEB_CYCLES consecutive cycles.
//   clk_100   : system clock
//   rst_100   : synchronous active-high reset
//   btn_rst_n : raw asynchronous button, active low
//   fire      : one-cycle request pulse, once per press
module reset_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1024
) (
    input  logic clk_100,
    input  logic rst_100,
    input  logic btn_rst_n,
    output logic fire
);

    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       deb_cnt;
    logic                   btn_sync;

    // Synchronizer chain; flops reset to 1 so a released button is assumed.
    always_ff @(posedge clk_100) begin
        if (rst_100) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_rst_n};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // The counter saturates at DEB_CYCLES, so the compare against
    // DEB_CYCLES-1 can only be true once per press; releasing clears it.
    always_ff @(posedge clk_100) begin
        if (rst_100) begin
            deb_cnt <= '0;
            fire    <= 1'b0;
        end else begin
            fire <= !btn_sync && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
            if (btn_sync) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_W'(DEB_CYCLES)) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator for all clk_100 logic. Releases memory controller,
// peripherals and CPU core in that order after any reset source, and records
// the cause and any memory-calibration timeout for firmware.
//   clk_100 : system clock, 100 MHz
//   rst_100 : synchronous active-high power-on reset
//   bus     : request inputs and staged reset outputs (slave side)
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 1024,
    parameter int STRETCH_CYCLES = 64,
    parameter int MEM_TIMEOUT    = 65535,
    parameter int CPU_DELAY      = 16
) (
    input  logic               clk_100,
    input  logic               rst_100,
    reset_sequencer_if.slave   bus
);

    localparam int STRETCH_W = $clog2(STRETCH_CYCLES) + 1;
    localparam int TMO_W     = $clog2(MEM_TIMEOUT) + 1;
    localparam int DLY_W     = $clog2(CPU_DELAY) + 1;

    state_t               state;
    state_t               next_state;
    logic [STRETCH_W-1:0] stretch_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [DLY_W-1:0]     dly_cnt;
    logic                 btn_fire;
    logic                 req;
    logic [2:0]           req_cause;
    logic                 stretch_done;
    logic                 tmo_hit;
    logic                 dly_done;
    logic                 mem_next, per_next, cpu_next;
    logic                 mem_q, per_q, cpu_q, busy_q;
    logic [2:0]           cause_q;
    logic                 timeout_q;

    reset_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_debounce (
        .clk_100   (clk_100),
        .rst_100   (rst_100),
        .btn_rst_n (bus.btn_rst_n),
        .fire      (btn_fire)
    );

    always_comb begin
        req_cause             = 3'b000;
        req_cause[CAUSE_BTN]  = btn_fire;
        req_cause[CAUSE_SW]   = bus.sw_rst_req;
        req_cause[CAUSE_WDOG] = bus.wdog_exp;
    end

    assign req          = |req_cause;
    assign stretch_done = (stretch_cnt == STRETCH_W'(STRETCH_CYCLES - 1));
    assign tmo_hit      = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
    assign dly_done     = (dly_cnt == DLY_W'(CPU_DELAY - 1));

    // Next-state decode; a request overrides every other transition.
    always_comb begin
        next_state = state;
        if (req) begin
            next_state = ASSERT;
        end else begin
            case (state)
                ASSERT:   if (stretch_done) next_state = MEM_WAIT;
                MEM_WAIT: if (bus.mem_init_done || tmo_hit) next_state = PER_REL;
                PER_REL:  if (dly_done) next_state = RUN;
                RUN:      next_state = RUN;
                default:  next_state = ASSERT;
            endcase
        end
    end

    // Reset levels are decoded from the next state and then registered, so
    // the pins are plain flops and release order follows the state order.
    always_comb begin
        mem_next = (next_state == ASSERT);
        per_next = (next_state == ASSERT) || (next_state == MEM_WAIT);
        cpu_next = (next_state != RUN);
    end

    // State, output flops, counters and firmware status. Every entry into
    // ASSERT clears all counters, so each counter only needs to saturate.
    always_ff @(posedge clk_100) begin
        if (rst_100) begin
            state       <= ASSERT;
            mem_q       <= 1'b1;
            per_q       <= 1'b1;
            cpu_q       <= 1'b1;
            busy_q      <= 1'b1;
            cause_q     <= 3'b000;
            timeout_q   <= 1'b0;
            stretch_cnt <= '0;
            tmo_cnt     <= '0;
            dly_cnt     <= '0;
        end else begin
            state  <= next_state;
            mem_q  <= mem_next;
            per_q  <= per_next;
            cpu_q  <= cpu_next;
            busy_q <= cpu_next;
            if (req) begin
                cause_q     <= req_cause;
                timeout_q   <= 1'b0;
                stretch_cnt <= '0;
                tmo_cnt     <= '0;
                dly_cnt     <= '0;
            end else begin
                if (state == ASSERT && !stretch_done) begin
                    stretch_cnt <= stretch_cnt + 1'b1;
                end
                if (state == MEM_WAIT && !bus.mem_init_done) begin
                    if (tmo_hit) begin
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                if (state == PER_REL && !dly_done) begin
                    dly_cnt <= dly_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.rst_mem     = mem_q;
    assign bus.rst_per     = per_q;
    assign bus.rst_cpu     = cpu_q;
    assign bus.seq_busy    = busy_q;
    assign bus.rst_cause   = cause_q;
    assign bus.mem_timeout = timeout_q;

endmodule
